// File: rtl/pattern_pkg.sv
// Shared defaults and FSM encoding for the
// pattern stream serializer slice.
package pattern_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_DIV_W      = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pattern_word_fifo.sv
// Synchronous word FIFO with clear, occupancy count
// and pointers wrapping modulo DEPTH.
module pattern_word_fifo
    import pattern_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    localparam int AW    = ptr_w(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem[rd_ptr];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pattern_stream_serializer.sv
// Buffers parallel words and shifts them out one bit
// per programmable period, feeding a serial pattern detector.
module pattern_stream_serializer
    import pattern_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DIV_W      = DEF_DIV_W,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1,
    localparam int BW        = ptr_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              msb_first,
    input  logic [DIV_W-1:0]  div,
    input  logic              flush,
    output logic              dout,
    output logic              bit_strobe,
    output logic              busy,
    output logic [LW-1:0]     level
);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_q;
    logic              msb_q;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              period_end;
    logic              last_end;
    logic              load;

    assign in_ready   = !full;
    assign busy       = (state == SHIFT);
    assign push       = in_valid && in_ready && !flush;
    assign period_end = (cnt == div_q);
    assign last_end   = busy && period_end && (bit_cnt == '0);
    assign load       = !flush && !empty && (!busy || last_end);
    assign nxt        = msb_q ? (shreg << 1) : (shreg >> 1);

    function automatic logic pick(
        input logic [DATA_W-1:0] w,
        input logic              m
    );
        return m ? w[DATA_W-1] : w[0];
    endfunction

    pattern_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (load),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (level)
    );

    // Loading at the end of the last bit gives gapless words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dout       <= 1'b0;
            bit_strobe <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
            div_q      <= '0;
            msb_q      <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            dout       <= 1'b0;
            bit_strobe <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= '0;
        end else if (load) begin
            state      <= SHIFT;
            shreg      <= head;
            dout       <= pick(head, msb_first);
            bit_strobe <= 1'b1;
            bit_cnt    <= BW'(DATA_W - 1);
            cnt        <= '0;
            div_q      <= div;
            msb_q      <= msb_first;
        end else if (busy) begin
            if (!period_end) begin
                cnt        <= cnt + DIV_W'(1);
                bit_strobe <= 1'b0;
            end else if (bit_cnt == '0) begin
                state      <= IDLE;
                dout       <= 1'b0;
                bit_strobe <= 1'b0;
                cnt        <= '0;
            end else begin
                shreg      <= nxt;
                dout       <= pick(nxt, msb_q);
                bit_strobe <= 1'b1;
                bit_cnt    <= bit_cnt - BW'(1);
                cnt        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_stream_serializer.sv
// Directed bench for pattern_stream_serializer: serial order,
// periods, buffering, reset and flush behaviour.
module tb_pattern_stream_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       msb_first;
    logic [7:0] div;
    logic       flush;
    logic       dout;
    logic       bit_strobe;
    logic       busy;
    logic [2:0] level;

    int vectors = 0;
    int miscompares = 0;

    logic collect = 1'b0;
    logic bits[$];

    pattern_stream_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .msb_first  (msb_first),
        .div        (div),
        .flush      (flush),
        .dout       (dout),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .level      (level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (collect && bit_strobe) bits.push_back(dout);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        vectors++;
        if ({dout, bit_strobe, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_out got %b want 000", {dout, bit_strobe, busy});
        end
        vectors++;
        if (level !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_level got %0d want 0", level);
        end
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_msb_div0();
        logic [7:0] w;
        logic [3:0] hist;
        int fires;
        w = 8'hD0;
        hist = '0;
        fires = 0;
        msb_first = 1'b1;
        div = 8'd0;
        push_word(w);
        vectors++;
        if (dout !== 1'b0 || level !== 3'd1) begin
            miscompares++;
            $display("FAIL d0_pre dout %b level %0d want 0 1", dout, level);
        end
        tick();
        for (int i = 0; i < 9; i++) begin
            logic e;
            e = (i < 8) ? w[7-i] : 1'b0;
            vectors++;
            if (dout !== e || bit_strobe !== (i < 8)) begin
                miscompares++;
                $display("FAIL d0_bit%0d dout %b strobe %b want %b %b",
                         i, dout, bit_strobe, e, (i < 8));
            end
            hist = {hist[2:0], dout};
            if (hist == 4'b1101) fires++;
            tick();
        end
        vectors++;
        if (fires !== 1) begin
            miscompares++;
            $display("FAIL d0_detect got %0d want 1", fires);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL d0_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        exp = 16'h0BB0;
        msb_first = 1'b0;
        div = 8'd0;
        in_valid = 1'b1;
        in_data = 8'hB0;
        tick();
        in_data = 8'h0B;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (dout !== exp[i] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_bit%0d dout %b busy %b want %b 1",
                         i, dout, busy, exp[i]);
            end
            tick();
        end
        vectors++;
        if (dout !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end dout %b busy %b want 0 0", dout, busy);
        end
    endtask

    task automatic test_div2();
        msb_first = 1'b1;
        div = 8'd2;
        push_word(8'hFF);
        tick();
        for (int i = 0; i < 24; i++) begin
            vectors++;
            if (dout !== 1'b1 || busy !== 1'b1 ||
                bit_strobe !== (i % 3 == 0)) begin
                miscompares++;
                $display("FAIL div2_c%0d dout %b busy %b strobe %b want 1 1 %b",
                         i, dout, busy, bit_strobe, (i % 3 == 0));
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || dout !== 1'b0) begin
            miscompares++;
            $display("FAIL div2_end busy %b dout %b want 0 0", busy, dout);
        end
    endtask

    task automatic test_fill();
        int acc;
        int wait_cyc;
        logic rdy;
        logic [7:0] got;
        bits.delete();
        collect = 1'b1;
        msb_first = 1'b1;
        div = 8'd3;
        acc = 0;
        in_valid = 1'b1;
        in_data = 8'hA0;
        for (int c = 0; c < 12; c++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                acc++;
                in_data = 8'hA0 + 8'(acc);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (acc !== 5) begin
            miscompares++;
            $display("FAIL fill_accepts got %0d want 5", acc);
        end
        vectors++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full level %0d ready %b want 4 0", level, in_ready);
        end
        wait_cyc = 0;
        while ((busy || level != 0) && wait_cyc < 400) begin
            tick();
            wait_cyc++;
        end
        vectors++;
        if (busy || level != 0) begin
            miscompares++;
            $display("FAIL fill_drain timeout busy %b level %0d want 0 0", busy, level);
        end
        collect = 1'b0;
        vectors++;
        if (bits.size() !== 40) begin
            miscompares++;
            $display("FAIL fill_bits got %0d want 40", bits.size());
        end else begin
            for (int w = 0; w < 5; w++) begin
                got = '0;
                for (int b = 0; b < 8; b++) got = {got[6:0], bits[w*8+b]};
                vectors++;
                if (got !== 8'hA0 + 8'(w)) begin
                    miscompares++;
                    $display("FAIL fill_word%0d got %h want %h", w, got, 8'hA0 + 8'(w));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        msb_first = 1'b1;
        div = 8'd0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        tick();
        in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (dout !== 1'b1 || level !== 3'd1) begin
            miscompares++;
            $display("FAIL rst_pre dout %b level %0d want 1 1", dout, level);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (dout !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || bit_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid dout %b level %0d busy %b strobe %b want 0 0 0 0",
                     dout, level, busy, bit_strobe);
        end
        #2;
        reset = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || dout !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ready ready %b dout %b want 1 0", in_ready, dout);
        end
        w = 8'hD0;
        push_word(w);
        tick();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (dout !== w[7-i]) begin
                miscompares++;
                $display("FAIL rst_after_bit%0d got %b want %b", i, dout, w[7-i]);
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || dout !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after_end busy %b dout %b want 0 0", busy, dout);
        end
    endtask

    task automatic test_flush();
        int bad;
        msb_first = 1'b1;
        div = 8'd3;
        in_valid = 1'b1;
        in_data = 8'hFF;
        tick();
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        tick();
        in_data = 8'h44;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (level !== 3'd3 || busy !== 1'b1 || dout !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre level %0d busy %b dout %b want 3 1 1",
                     level, busy, dout);
        end
        bits.delete();
        collect = 1'b1;
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (dout !== 1'b0 || busy !== 1'b0 || level !== 3'd0 || bit_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_now dout %b busy %b level %0d strobe %b want 0 0 0 0",
                     dout, busy, level, bit_strobe);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (dout || busy || bit_strobe) bad++;
            tick();
        end
        collect = 1'b0;
        vectors++;
        if (bad !== 0 || bits.size() !== 0) begin
            miscompares++;
            $display("FAIL flush_quiet active %0d bits %0d want 0 0", bad, bits.size());
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_data = '0;
        msb_first = 1'b1;
        div = '0;
        flush = 1'b0;
        test_reset();
        test_msb_div0();
        test_back_to_back();
        test_div2();
        test_fill();
        test_reset_mid();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
